irrigation_countdown_timer: RTL and testbench

- Upstream stage of the 7-segment timer display path in the automated irrigation controller.
- Holds a watering countdown in whole seconds and drives the valve enable while the countdown runs.
- Presents the remaining time as a 4-bit binary digit (0..9) that feeds the display decoder directly.
- Contains an internal prescaler that turns the system clock into a 1-second tick.

---
 rtl/irrigation_countdown_timer_pkg.sv | 12 +
 rtl/irrigation_countdown_timer_if.sv | 30 +++
 rtl/irrigation_countdown_timer_tick_prescaler.sv | 25 ++
 rtl/irrigation_countdown_timer.sv | 101 ++++++++++
 tb/tb_irrigation_countdown_timer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/irrigation_countdown_timer_pkg.sv
// rtl/irrigation_countdown_timer_pkg.sv - shared constants for the irrigation countdown timer
package irrigation_countdown_timer_pkg;

    localparam int CNT_W     = 4;
    localparam int DIGIT_MAX = 9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_PAUSED = 2'd3;

endpackage

// File: rtl/irrigation_countdown_timer_if.sv
// rtl/irrigation_countdown_timer_if.sv - control/status bundle of the countdown timer; pause under TIMER_PAUSE_EN
interface irrigation_countdown_timer_if #(
    parameter int CNT_W = irrigation_countdown_timer_pkg::CNT_W
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] preset;
`ifdef TIMER_PAUSE_EN
    logic             pause;
`endif
    logic [CNT_W-1:0] count;
    logic             valve_on;
    logic             done;

    modport master (
        output start, abort, preset,
`ifdef TIMER_PAUSE_EN
        output pause,
`endif
        input  count, valve_on, done
    );

    modport slave (
        input  start, abort, preset,
`ifdef TIMER_PAUSE_EN
        input  pause,
`endif
        output count, valve_on, done
    );
endinterface

// File: rtl/irrigation_countdown_timer_tick_prescaler.sv
// rtl/irrigation_countdown_timer_tick_prescaler.sv - reusable TICK_DIV prescaler, one tick per TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] r_cnt;

    assign tick = enable && !clear && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/irrigation_countdown_timer.sv
// rtl/irrigation_countdown_timer.sv - watering countdown FSM driving valve and display digit; pause via TIMER_PAUSE_EN
module irrigation_countdown_timer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_COUNT = irrigation_countdown_timer_pkg::DIGIT_MAX,
    parameter int CNT_W     = irrigation_countdown_timer_pkg::CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    irrigation_countdown_timer_if.slave  bus
);
    import irrigation_countdown_timer_pkg::*;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_valve_on;
    logic             r_done;
    logic [CNT_W-1:0] w_load;
    logic             w_tick;
    logic             w_ps_enable;
    logic             w_ps_clear;

    assign w_load = (bus.preset > CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : bus.preset;

    // Prescaler only runs in RUN; it keeps its value across PAUSED and is zeroed elsewhere.
    assign w_ps_enable = (r_state == ST_RUN);
    assign w_ps_clear  = bus.abort || (r_state == ST_IDLE) || (r_state == ST_DONE);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (w_ps_enable),
        .clear  (w_ps_clear),
        .tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_valve_on <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort && (bus.preset != '0)) begin
                        r_count    <= w_load;
                        r_valve_on <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_count    <= '0;
                        r_valve_on <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_tick && (r_count <= CNT_W'(1))) begin
                        r_count    <= '0;
                        r_valve_on <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        if (w_tick) begin
                            r_count <= r_count - 1'b1;
                        end
`ifdef TIMER_PAUSE_EN
                        if (bus.pause) begin
                            r_valve_on <= 1'b0;
                            r_state    <= ST_PAUSED;
                        end
`endif
                    end
                end
`ifdef TIMER_PAUSE_EN
                ST_PAUSED: begin
                    if (bus.abort) begin
                        r_count    <= '0;
                        r_valve_on <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (!bus.pause) begin
                        r_valve_on <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_count    <= '0;
                    r_valve_on <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.count    = r_count;
    assign bus.valve_on = r_valve_on;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// tb/tb_irrigation_countdown_timer.sv - scoreboard bench for the irrigation countdown timer
module tb_irrigation_countdown_timer;

    typedef struct {
        int load;
        int run_cycles;
        int pause_cycles;
        bit exp_done;
    } txn_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   sim_end = 1'b0;
    txn_t exp_q [2][$];
    bit   mon_active [2];

    irrigation_countdown_timer_if #(.CNT_W(4)) bus0 ();
    irrigation_countdown_timer_if #(.CNT_W(4)) bus1 ();

    irrigation_countdown_timer #(.TICK_DIV(4), .MAX_COUNT(9), .CNT_W(4)) dut0 (
        .clk (clk), .rst (rst0), .bus (bus0.slave)
    );
    irrigation_countdown_timer #(.TICK_DIV(1), .MAX_COUNT(9), .CNT_W(4)) dut1 (
        .clk (clk), .rst (rst1), .bus (bus1.slave)
    );

    logic [3:0] m_cnt   [2];
    logic       m_valve [2];
    logic       m_done  [2];
    assign m_cnt[0]   = bus0.count;
    assign m_valve[0] = bus0.valve_on;
    assign m_done[0]  = bus0.done;
    assign m_cnt[1]   = bus1.count;
    assign m_valve[1] = bus1.valve_on;
    assign m_done[1]  = bus1.done;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int p);
        return (p > 9) ? 9 : p;
    endfunction

    // Reference: count in the k-th valve-on cycle is load - k/T; a run ends with
    // done after load*T valve cycles, or silently when aborted/reset.
    task automatic monitor(input int u, input int tdiv);
        txn_t cur;
        int   k  = 0;
        int   pk = 0;
        cur = '{0, 0, 0, 1'b0};
        mon_active[u] = 1'b0;
        while (!sim_end) begin
            @(negedge clk);
            if (!mon_active[u] && m_valve[u] && exp_q[u].size() != 0) begin
                cur = exp_q[u].pop_front();
                mon_active[u] = 1'b1;
                k  = 0;
                pk = 0;
            end
            if (!mon_active[u]) begin
                check($sformatf("u%0d idle {count,valve,done}", u),
                      int'({m_cnt[u], m_valve[u], m_done[u]}), 0);
            end else if (m_valve[u]) begin
                check($sformatf("u%0d count", u), int'(m_cnt[u]), cur.load - k / tdiv);
                check($sformatf("u%0d done while running", u), int'(m_done[u]), 0);
                k++;
            end else if (m_done[u] || m_cnt[u] == 4'd0) begin
                check($sformatf("u%0d done flag", u), int'(m_done[u]), int'(cur.exp_done));
                check($sformatf("u%0d end count", u), int'(m_cnt[u]), 0);
                check($sformatf("u%0d valve cycles", u), k, cur.run_cycles);
                check($sformatf("u%0d paused cycles", u), pk, cur.pause_cycles);
                mon_active[u] = 1'b0;
            end else begin
                check($sformatf("u%0d paused count", u), int'(m_cnt[u]), cur.load - k / tdiv);
                pk++;
            end
        end
    endtask

    initial monitor(0, 4);
    initial monitor(1, 1);

    task automatic run0(input int p, input int r, input bit start_in_done);
        int load = clamp(p);
        int c;
        exp_q[0].push_back('{load, load * 4, 0, 1'b1});
        bus0.start = 1'b1; bus0.preset = 4'(p);
        cyc(1);
        bus0.start = 1'b0; bus0.preset = 4'($urandom);
        c = 1;
        if (r > 0) begin
            cyc(r - 1);
            bus0.start = 1'b1; bus0.preset = 4'($urandom_range(15, 1));
            cyc(1);
            bus0.start = 1'b0;
            c = r + 1;
        end
        cyc(load * 4 + 1 - c);
        if (start_in_done) begin
            bus0.start = 1'b1; bus0.preset = 4'($urandom_range(15, 1));
        end
        cyc(1);
        bus0.start = 1'b0;
    endtask

    task automatic abort0(input int p, input int j, input bit use_rst);
        int load = clamp(p);
        exp_q[0].push_back('{load, j, 0, 1'b0});
        bus0.start = 1'b1; bus0.preset = 4'(p);
        cyc(1);
        bus0.start = 1'b0;
        cyc(j - 1);
        if (use_rst) rst0 = 1'b1; else bus0.abort = 1'b1;
        cyc(1);
        rst0 = 1'b0; bus0.abort = 1'b0;
    endtask

    task automatic noop0(input int kind);
        case (kind)
            0: begin bus0.start = 1'b1; bus0.preset = 4'd0; end
            1: begin bus0.start = 1'b1; bus0.abort = 1'b1; bus0.preset = 4'($urandom_range(15, 1)); end
            default: bus0.abort = 1'b1;
        endcase
        cyc(1);
        bus0.start = 1'b0; bus0.abort = 1'b0;
        cyc(1);
    endtask

`ifdef TIMER_PAUSE_EN
    task automatic pause0(input int p, input int j, input int hold);
        int load = clamp(p);
        exp_q[0].push_back('{load, load * 4, hold, 1'b1});
        bus0.start = 1'b1; bus0.preset = 4'(p);
        cyc(1);
        bus0.start = 1'b0;
        cyc(j - 1);
        bus0.pause = 1'b1;
        cyc(hold);
        bus0.pause = 1'b0;
        cyc(1);
        cyc(load * 4 + 1 - (j + 1));
        cyc(1);
    endtask
`endif

    initial begin
        int op, p, load;
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.preset = 4'd0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.preset = 4'd0;
`ifdef TIMER_PAUSE_EN
        bus0.pause = 1'b0;
        bus1.pause = 1'b0;
`endif
        cyc(3);
        rst0 = 1'b0; rst1 = 1'b0;
        cyc(2);

        run0(3, 0, 1'b0);
        run0(12, 0, 1'b0);
        noop0(0);
        abort0(3, 8, 1'b0);
        run0(3, 6, 1'b0);
        abort0(4, 7, 1'b1);
        run0(2, 0, 1'b1);
        noop0(1);
`ifdef TIMER_PAUSE_EN
        pause0(2, 3, 5);
        pause0(2, 4, 3);
`endif

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(5, 0);
            p  = $urandom_range(15, 1);
            load = clamp(p);
            case (op)
                0, 1: run0(p, 0, $urandom_range(1, 0) == 1);
                2:    run0(p, $urandom_range(load * 4, 1), 1'b0);
                3:    abort0(p, $urandom_range(load * 4, 1), $urandom_range(1, 0) == 1);
                4:    noop0($urandom_range(2, 0));
                default: cyc($urandom_range(3, 0));
            endcase
        end

        exp_q[1].push_back('{1, 1, 0, 1'b1});
        bus1.start = 1'b1; bus1.preset = 4'd1;
        cyc(1);
        bus1.start = 1'b0;
        cyc(2);
        exp_q[1].push_back('{9, 9, 0, 1'b1});
        bus1.start = 1'b1; bus1.preset = 4'd12;
        cyc(1);
        bus1.start = 1'b0;
        cyc(10);
        exp_q[1].push_back('{5, 3, 0, 1'b0});
        bus1.start = 1'b1; bus1.preset = 4'd5;
        cyc(1);
        bus1.start = 1'b0;
        cyc(2);
        bus1.abort = 1'b1;
        cyc(1);
        bus1.abort = 1'b0;

        cyc(5);
        sim_end = 1'b1;
        cyc(2);
        check("u0 pending expectations", exp_q[0].size(), 0);
        check("u1 pending expectations", exp_q[1].size(), 0);
        check("u0 run left open", int'(mon_active[0]), 0);
        check("u1 run left open", int'(mon_active[1]), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
